// File: rtl/serial_shift_out_pkg.sv
// rtl/serial_shift_out_pkg.sv - shared state encodings for serial_shift_out
// Purpose: FSM state type shared by the shifter and any bench that probes its state.
// Contents: state_t (ST_CLEAR, ST_IDLE, ST_SHIFT, ST_LATCH).
package serial_shift_out_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_LATCH = 2'd3
  } state_t;

endpackage

// File: rtl/serial_shift_out_if.sv
// rtl/serial_shift_out_if.sv - frame handshake interface for serial_shift_out
// Purpose: carries one WIDTH-bit frame per valid/ready handshake.
// Signals: data (frame), valid (frame available), ready (sink can accept).
// Modports: master drives data/valid, slave drives ready.
interface serial_shift_out_if #(
  parameter int WIDTH = 64
) ();

  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/serial_shift_out_phase_timer.sv
// rtl/serial_shift_out_phase_timer.sv - per-phase clk-cycle timer
// Purpose: down-counter loaded with CLK_DIV-1; done is high while the count is zero,
//          which lasts one cycle because the owner reloads on every phase change.
// Ports: clk, rst (async, active-high), load (reload request), done (phase complete).
module serial_shift_out_phase_timer #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic done
);

  localparam int            TW     = $clog2(CLK_DIV + 1);
  localparam logic [TW-1:0] RELOAD = TW'(CLK_DIV - 1);

  logic [TW-1:0] count;

  // Holds at zero rather than wrapping if nobody reloads it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= RELOAD;
    end else if (load) begin
      count <= RELOAD;
    end else if (count != '0) begin
      count <= count - TW'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/serial_shift_out.sv
// rtl/serial_shift_out.sv - parallel-to-serial driver for 74HC595-style chains
// Purpose: accepts a frame on bus, shifts it out on sclk/sdo, then pulses spen to latch it.
//          Holds sclr_n low for CLK_DIV cycles after reset to clear the chain.
// Ports: clk, rst (async, active-high), bus (slave: data/valid in, ready out),
//        busy (~ready), sclk (shift clock), sdo (serial data), sclr_n (chain clear, low),
//        spen (latch pulse, high). All outputs are registered.
module serial_shift_out
  import serial_shift_out_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter int CLK_DIV   = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_shift_out_if.slave    bus,
  output logic                 busy,
  output logic                 sclk,
  output logic                 sdo,
  output logic                 sclr_n,
  output logic                 spen
);

  localparam int BW = $clog2(WIDTH + 1);

  state_t           state, state_nx;
  logic [WIDTH-1:0] shreg, shreg_nx, shifted;
  logic [BW-1:0]    bitcnt, bitcnt_nx;
  logic             ready_q, ready_nx, busy_nx;
  logic             sclk_nx, sdo_nx, sclr_n_nx, spen_nx;
  logic             load, done, last_bit;

  function automatic logic lead_bit(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  serial_shift_out_phase_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .done (done)
  );

  // The bit currently on sdo always sits at the lead end of shreg.
  assign shifted  = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
  assign last_bit = (bitcnt == BW'(1));
  assign bus.ready = ready_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_CLEAR;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_CLEAR: if (done) state_nx = ST_IDLE;
      ST_IDLE:  if (bus.valid) state_nx = ST_SHIFT;
      ST_SHIFT: if (done && sclk && last_bit) state_nx = ST_LATCH;
      ST_LATCH: if (done) state_nx = ST_IDLE;
      default:  state_nx = ST_CLEAR;
    endcase
  end

  // Next values for every registered output; sclk itself tells which half of a bit we are in.
  always_comb begin
    sclk_nx   = sclk;
    sdo_nx    = sdo;
    sclr_n_nx = sclr_n;
    spen_nx   = spen;
    ready_nx  = ready_q;
    shreg_nx  = shreg;
    bitcnt_nx = bitcnt;
    load      = 1'b0;
    case (state)
      ST_CLEAR: begin
        if (done) begin
          sclr_n_nx = 1'b1;
          ready_nx  = 1'b1;
          load      = 1'b1;
        end
      end
      ST_IDLE: begin
        // Keep the timer primed so the first low phase is a full CLK_DIV long.
        load = 1'b1;
        if (bus.valid) begin
          ready_nx  = 1'b0;
          shreg_nx  = bus.data;
          bitcnt_nx = BW'(WIDTH);
          sclk_nx   = 1'b0;
          sdo_nx    = lead_bit(bus.data);
        end
      end
      ST_SHIFT: begin
        if (done) begin
          load = 1'b1;
          if (!sclk) begin
            sclk_nx = 1'b1;
          end else begin
            sclk_nx   = 1'b0;
            shreg_nx  = shifted;
            bitcnt_nx = bitcnt - BW'(1);
            if (last_bit) begin
              sdo_nx  = 1'b0;
              spen_nx = 1'b1;
            end else begin
              sdo_nx = lead_bit(shifted);
            end
          end
        end
      end
      ST_LATCH: begin
        if (done) begin
          load     = 1'b1;
          spen_nx  = 1'b0;
          ready_nx = 1'b1;
        end
      end
      default: ;
    endcase
    busy_nx = ~ready_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk    <= 1'b0;
      sdo     <= 1'b0;
      sclr_n  <= 1'b0;
      spen    <= 1'b0;
      ready_q <= 1'b0;
      busy    <= 1'b1;
      shreg   <= '0;
      bitcnt  <= '0;
    end else begin
      sclk    <= sclk_nx;
      sdo     <= sdo_nx;
      sclr_n  <= sclr_n_nx;
      spen    <= spen_nx;
      ready_q <= ready_nx;
      busy    <= busy_nx;
      shreg   <= shreg_nx;
      bitcnt  <= bitcnt_nx;
    end
  end

endmodule

// File: tb/tb_serial_shift_out.sv
// tb/tb_serial_shift_out.sv - directed self-checking bench for serial_shift_out
module tb_serial_shift_out;
  import serial_shift_out_pkg::*;

  localparam int CDA = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  logic busy_a, sclk_a, sdo_a, sclr_n_a, spen_a, ready_a;
  logic busy_b, sclk_b, sdo_b, sclr_n_b, spen_b, ready_b;

  serial_shift_out_if #(.WIDTH(64)) bus_a ();
  serial_shift_out_if #(.WIDTH(8))  bus_b ();

  assign ready_a = bus_a.ready;
  assign ready_b = bus_b.ready;

  serial_shift_out #(.WIDTH(64), .CLK_DIV(CDA), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst(rst_a), .bus(bus_a.slave), .busy(busy_a),
    .sclk(sclk_a), .sdo(sdo_a), .sclr_n(sclr_n_a), .spen(spen_a)
  );

  serial_shift_out #(.WIDTH(8), .CLK_DIV(1), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst(rst_b), .bus(bus_b.slave), .busy(busy_b),
    .sclk(sclk_b), .sdo(sdo_b), .sclr_n(sclr_n_b), .spen(spen_b)
  );

  int total = 0;
  int passed = 0;

  // Chain-side observers for instance A, sampled on the falling clk edge.
  logic        prev_sclk_a = 0, prev_sdo_a = 0, prev_spen_a = 0, prev_ready_a = 0;
  logic [63:0] cap_a = '0;
  int rises_a = 0, stable_a = 0, setup_err_a = 0, pulses_a = 0, spen_len_a = 0;
  int low_a = 0, last_low_a = 0;

  always @(negedge clk) begin
    prev_sclk_a  <= sclk_a;
    prev_sdo_a   <= sdo_a;
    prev_spen_a  <= spen_a;
    prev_ready_a <= ready_a;
    stable_a     <= (sdo_a != prev_sdo_a) ? 1 : stable_a + 1;
    if (sclk_a && !prev_sclk_a) begin
      rises_a <= rises_a + 1;
      cap_a   <= {cap_a[62:0], sdo_a};
      if (((sdo_a != prev_sdo_a) ? 1 : stable_a + 1) < CDA + 1) setup_err_a <= setup_err_a + 1;
    end
    if (sclk_a && prev_sclk_a && (sdo_a != prev_sdo_a)) setup_err_a <= setup_err_a + 1;
    if (spen_a && !prev_spen_a) begin
      pulses_a   <= pulses_a + 1;
      spen_len_a <= 1;
    end else if (spen_a) begin
      spen_len_a <= spen_len_a + 1;
    end
    if (rst_a) begin
      low_a <= 0;
    end else if (ready_a) begin
      if (!prev_ready_a) begin
        last_low_a <= low_a;
        low_a      <= 0;
      end
    end else begin
      low_a <= low_a + 1;
    end
  end

  // Observers for instance B.
  logic       prev_sclk_b = 0, prev_spen_b = 0, prev_ready_b = 0;
  logic [7:0] cap_b = '0;
  int rises_b = 0, pulses_b = 0, low_b = 0, last_low_b = 0, high_b = 0, last_high_b = 0;

  always @(negedge clk) begin
    prev_sclk_b  <= sclk_b;
    prev_spen_b  <= spen_b;
    prev_ready_b <= ready_b;
    if (sclk_b && !prev_sclk_b) begin
      rises_b <= rises_b + 1;
      cap_b   <= {sdo_b, cap_b[7:1]};
    end
    if (spen_b && !prev_spen_b) pulses_b <= pulses_b + 1;
    if (rst_b) begin
      low_b  <= 0;
      high_b <= 0;
    end else if (ready_b) begin
      high_b <= high_b + 1;
      if (!prev_ready_b) begin
        last_low_b <= low_b;
        low_b      <= 0;
      end
    end else begin
      low_b <= low_b + 1;
      if (prev_ready_b) begin
        last_high_b <= high_b;
        high_b      <= 0;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One step: just past the falling edge, after the observers have updated.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ready_a(input string tag, input int limit);
    for (int i = 0; i < limit && !ready_a; i++) tick();
    check(tag, ready_a, 1);
  endtask

  task automatic wait_ready_b(input string tag, input int limit);
    for (int i = 0; i < limit && !ready_b; i++) tick();
    check(tag, ready_b, 1);
  endtask

  task automatic send_a(input string tag, input logic [63:0] d);
    wait_ready_a({tag, "_idle"}, 3000);
    bus_a.data  = d;
    bus_a.valid = 1'b1;
    tick();
    bus_a.valid = 1'b0;
    check({tag, "_accept"}, ready_a, 0);
  endtask

  task automatic frame_a(input string tag, input logic [63:0] d);
    int br, bp;
    br = rises_a;
    bp = pulses_a;
    send_a(tag, d);
    wait_ready_a({tag, "_done"}, 1000);
    check({tag, "_rises"}, 64'(rises_a - br), 64);
    check({tag, "_bits"}, cap_a, d);
    check({tag, "_spen_pulses"}, 64'(pulses_a - bp), 1);
    check({tag, "_spen_len"}, 64'(spen_len_a), CDA);
    check({tag, "_ready_low"}, 64'(last_low_a), 516);
    check({tag, "_setup"}, 64'(setup_err_a), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int br, bp;
    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.data = '0;
    bus_a.valid = 1'b0;
    bus_b.data = '0;
    bus_b.valid = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_sclr_n", sclr_n_a, 0);
    check("rst_sclk", sclk_a, 0);
    check("rst_sdo", sdo_a, 0);
    check("rst_spen", spen_a, 0);
    check("rst_ready", ready_a, 0);
    check("rst_busy", busy_a, 1);
    check("rst_state", dut_a.state, ST_CLEAR);
    check("rst_b_ready", ready_b, 0);
    check("rst_b_busy", busy_b, 1);

    // Release: sclr_n low for CDA cycles, then clear released and ready together
    rst_a = 1'b0;
    rst_b = 1'b0;
    for (int i = 1; i < CDA; i++) begin
      tick();
      check("clear_sclr_n_low", sclr_n_a, 0);
      check("clear_ready_low", ready_a, 0);
    end
    tick();
    check("clear_sclr_n_high", sclr_n_a, 1);
    check("clear_ready_high", ready_a, 1);
    check("clear_busy_low", busy_a, 0);
    check("clear_b_sclr_n", sclr_n_b, 1);

    // Single frame with only the end bits set
    frame_a("single", 64'h8000_0000_0000_0001);

    // Random frames
    for (int k = 0; k < 3; k++) frame_a("random", {$urandom, $urandom});

    // valid pulsed mid-SHIFT is ignored
    br = rises_a;
    bp = pulses_a;
    send_a("busy_ign", 64'h0);
    repeat (100) tick();
    bus_a.data  = '1;
    bus_a.valid = 1'b1;
    repeat (3) tick();
    check("busy_ign_ready", ready_a, 0);
    check("busy_ign_busy", busy_a, 1);
    bus_a.valid = 1'b0;
    wait_ready_a("busy_ign_done", 1000);
    check("busy_ign_bits", cap_a, 64'h0);
    check("busy_ign_rises", 64'(rises_a - br), 64);
    check("busy_ign_pulses", 64'(pulses_a - bp), 1);
    repeat (40) tick();
    check("busy_ign_no_extra", 64'(rises_a - br), 64);
    check("busy_ign_still_idle", ready_a, 1);

    // Reset after the 20th sclk rise drops the frame
    br = rises_a;
    send_a("midrst", 64'hFFFF_0000_1234_5678);
    for (int i = 0; i < 1000 && (rises_a - br) < 20; i++) tick();
    check("midrst_rises20", 64'(rises_a - br), 20);
    check("midrst_sclk_before", sclk_a, 1);
    bp = pulses_a;
    rst_a = 1'b1;
    #1;
    check("midrst_sclk", sclk_a, 0);
    check("midrst_sdo", sdo_a, 0);
    check("midrst_spen", spen_a, 0);
    check("midrst_sclr_n", sclr_n_a, 0);
    check("midrst_ready", ready_a, 0);
    check("midrst_busy", busy_a, 1);
    repeat (2) tick();
    rst_a = 1'b0;
    tick();
    check("midrst_clear_rerun", sclr_n_a, 0);
    wait_ready_a("midrst_clear_done", 20);
    check("midrst_sclr_n_rel", sclr_n_a, 1);
    check("midrst_no_spen", 64'(pulses_a - bp), 0);
    frame_a("after_rst", 64'hA5A5_A5A5_A5A5_A5A5);

    // Instance B: WIDTH=8, CLK_DIV=1, LSB first, valid held across two frames
    br = rises_b;
    bp = pulses_b;
    wait_ready_b("b_idle", 20);
    bus_b.data  = 8'h01;
    bus_b.valid = 1'b1;
    tick();
    check("b_accept1", ready_b, 0);
    bus_b.data = 8'hC6;
    for (int i = 0; i < 5 && !sclk_b; i++) tick();
    check("b_first_sclk", sclk_b, 1);
    check("b_first_bit", sdo_b, 1);
    wait_ready_b("b_done1", 40);
    check("b_ready_low1", 64'(last_low_b), 17);
    check("b_bits1", cap_b, 8'h01);
    check("b_rises1", 64'(rises_b - br), 8);
    tick();
    check("b_accept2", ready_b, 0);
    check("b_idle_gap", 64'(last_high_b), 1);
    wait_ready_b("b_done2", 40);
    bus_b.valid = 1'b0;
    check("b_ready_low2", 64'(last_low_b), 17);
    check("b_bits2", cap_b, 8'hC6);
    check("b_rises2", 64'(rises_b - br), 16);
    check("b_pulses", 64'(pulses_b - bp), 2);
    repeat (5) tick();
    check("b_no_third", 64'(rises_b - br), 16);
    check("b_idle_end", ready_b, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
